// File: rtl/bus_debug_master.sv
// UART-driven bus initiator: 'W' addr data issues a write strobe, 'R' addr reads back over tx.
// Define DBG_READBACK_EN to build in the 'R' command and the TX serialiser.
module bus_debug_master #(
   parameter int CLKS_PER_BIT = 104,
   parameter int TIMEOUT_BITS = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   output logic       halt,
   output logic       write,
   output logic       read,
   output logic [7:0] address,
   output logic [7:0] dout,
   input  logic [7:0] din,
   output logic       err
);

   localparam int CW        = $clog2(CLKS_PER_BIT);
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW        = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
   localparam logic [7:0]    CMD_W     = 8'h57;

   // state | meaning: IDLE wait command, W_ADDR/W_DATA/R_ADDR collect bytes, DO_* strobe, CAPTURE latch din, SEND tx frame
   typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, DO_WRITE, R_ADDR, DO_READ, CAPTURE, SEND} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic          rst_q, rst_n;
   logic          rx_s1, rx_s2, rx_s3;
   rx_state_t     rx_st;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_idx;
   logic [7:0]    rx_sh;
   logic          rx_vld, rx_ferr;
   state_t        state;
   logic [TW-1:0] to_cnt;
   logic          busy, wait_fail;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) {rst_n, rst_q} <= 2'b00;
      else      {rst_n, rst_q} <= {rst_q, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {rx_s3, rx_s2, rx_s1} <= 3'b111;
         rx_st   <= RX_IDLE;
         rx_cnt  <= '0;
         rx_idx  <= '0;
         rx_sh   <= '0;
         rx_vld  <= 1'b0;
         rx_ferr <= 1'b0;
      end else begin
         {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
         rx_vld  <= 1'b0;
         rx_ferr <= 1'b0;
         case (rx_st)
            RX_IDLE:
               if (rx_s3 && !rx_s2) begin
                  rx_st  <= RX_START;
                  rx_cnt <= HALF_LAST;
               end
            RX_START:
               if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
               else if (!rx_s2) begin
                  rx_st  <= RX_DATA;
                  rx_cnt <= BIT_LAST;
                  rx_idx <= '0;
               end else rx_st <= RX_IDLE;
            RX_DATA:
               if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
               else begin
                  rx_sh  <= {rx_s2, rx_sh[7:1]};
                  rx_cnt <= BIT_LAST;
                  rx_idx <= rx_idx + 3'd1;
                  if (rx_idx == 3'd7) rx_st <= RX_STOP;
               end
            RX_STOP:
               if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
               else begin
                  rx_st   <= RX_IDLE;
                  rx_vld  <= rx_s2;
                  rx_ferr <= !rx_s2;
               end
            default: rx_st <= RX_IDLE;
         endcase
      end
   end

   assign busy      = state inside {DO_WRITE, DO_READ, CAPTURE, SEND};
   assign wait_fail = rx_ferr || (!rx_vld && to_cnt == '0);

`ifdef DBG_READBACK_EN
   localparam logic [7:0] CMD_R = 8'h52;
   logic [8:0]    tx_sh;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_left;
`else
   logic unused_din;
   assign unused_din = ^din;
   assign read = 1'b0;
   assign tx   = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         halt    <= 1'b0;
         write   <= 1'b0;
         address <= '0;
         dout    <= '0;
         err     <= 1'b0;
         to_cnt  <= '0;
`ifdef DBG_READBACK_EN
         read    <= 1'b0;
         tx      <= 1'b1;
         tx_sh   <= '1;
         tx_cnt  <= '0;
         tx_left <= '0;
`endif
      end else begin
         write <= 1'b0;
`ifdef DBG_READBACK_EN
         read  <= 1'b0;
`endif
         if (busy && (rx_vld || rx_ferr)) err <= 1'b1;
         case (state)
            IDLE:
               if (rx_ferr) err <= 1'b1;
               else if (rx_vld) begin
                  if (rx_sh == CMD_W) begin
                     state  <= W_ADDR;
                     halt   <= 1'b1;
                     err    <= 1'b0;
                     to_cnt <= TO_LAST;
                  end
`ifdef DBG_READBACK_EN
                  else if (rx_sh == CMD_R) begin
                     state  <= R_ADDR;
                     halt   <= 1'b1;
                     err    <= 1'b0;
                     to_cnt <= TO_LAST;
                  end
`endif
                  else err <= 1'b1;
               end
            W_ADDR, W_DATA, R_ADDR:
               if (wait_fail) begin
                  state <= IDLE;
                  halt  <= 1'b0;
                  err   <= 1'b1;
               end else if (!rx_vld) to_cnt <= to_cnt - 1'b1;
               else begin
                  to_cnt <= TO_LAST;
                  if (state == W_DATA) begin
                     dout  <= rx_sh;
                     write <= 1'b1;
                     state <= DO_WRITE;
                  end else begin
                     address <= rx_sh;
                     if (state == W_ADDR) state <= W_DATA;
                     else begin
                        state <= DO_READ;
`ifdef DBG_READBACK_EN
                        read  <= 1'b1;
`endif
                     end
                  end
               end
            DO_WRITE: begin
               halt  <= 1'b0;
               state <= IDLE;
            end
`ifdef DBG_READBACK_EN
            DO_READ: state <= CAPTURE;
            CAPTURE: begin
               tx      <= 1'b0;
               tx_sh   <= {1'b1, din};
               tx_cnt  <= BIT_LAST;
               tx_left <= 4'd9;
               state   <= SEND;
            end
            SEND:
               if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
               else if (tx_left == '0) begin
                  state <= IDLE;
                  halt  <= 1'b0;
               end else begin
                  tx      <= tx_sh[0];
                  tx_sh   <= {1'b1, tx_sh[8:1]};
                  tx_left <= tx_left - 1'b1;
                  tx_cnt  <= BIT_LAST;
               end
`endif
            default: begin
               state <= IDLE;
               halt  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bus_debug_master.md
# bus_debug_master

Serial-driven bus initiator that issues the same single-cycle `write`/`read` strobes the CPU issues on the 8-bit peripheral bus. It lets a host over a UART line poke and peek memory-mapped peripherals such as the LED register at address 128. It sits beside `cpu` in `top`: it raises `halt` while it owns the bus, and `top` muxes its strobes, address and data onto the peripheral decode in place of the CPU's. Bus timing matches the existing responders: they act on `write` at the clock edge, and they register `din` on the edge where `read` is high.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per UART bit; minimum 4.
- `TIMEOUT_BITS`, 255, idle bit-periods allowed between bytes of one command.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  UART receive, 8N1, LSB first, idle high; asynchronous to `clk`.
- `tx`  out  1  UART transmit, 8N1, idle high.
- `halt`  out  1  high while a command owns the bus; `top` selects this block's bus signals when high.
- `write`  out  1  one-cycle bus write strobe.
- `read`  out  1  one-cycle bus read strobe.
- `address`  out  8  bus address, valid while `write` or `read` is high.
- `dout`  out  8  write data, valid while `write` is high.
- `din`  in  8  read data; sampled one cycle after `read`.
- `err`  out  1  sticky error flag; cleared by reset or by the next accepted command byte.

## Operation
- Reset (async assert, sync release) forces `tx`=1, `halt`=0, `write`=0, `read`=0, `address`=0, `dout`=0, `err`=0, and the parser to IDLE.
- Reset mid-command abandons the command. No strobe is issued and no partial UART frame continues.
- RX path:
  - `rx` passes through a 2-flop synchroniser.
  - A falling edge starts a frame. The start bit is re-checked at half a bit; if it is high, the edge was a glitch and is ignored.
  - Data bits are sampled at bit centres.
  - The stop bit is sampled at its centre. If it is 0, the frame is a framing error: the byte is dropped, `err` is set and the parser returns to IDLE.
- Parser states and transitions:
  - IDLE: byte 0x57 ('W') goes to W_ADDR; byte 0x52 ('R') goes to R_ADDR; any other byte is discarded and sets `err`.
  - W_ADDR: the received byte is latched into `address`, then W_DATA.
  - W_DATA: the received byte is latched into `dout`, then DO_WRITE.
  - DO_WRITE: `write`=1 for exactly one cycle, then IDLE.
  - R_ADDR: the received byte is latched into `address`, then DO_READ.
  - DO_READ: `read`=1 for exactly one cycle, then CAPTURE.
  - CAPTURE: `din` is latched into the TX shift register, then SEND.
  - SEND: one 8N1 frame is transmitted; the state ends after the full stop bit, then IDLE.
- `halt` rises the cycle after a command byte is accepted. It falls the cycle after the `write` strobe, or the cycle after SEND ends.
- Inter-byte timeout: in W_ADDR, W_DATA or R_ADDR, if no byte completes within `TIMEOUT_BITS` bit periods, the parser returns to IDLE, sets `err` and drops `halt`. No strobe is issued.
- Bytes that complete while in DO_*, CAPTURE or SEND are discarded and set `err`.
- `address` and `dout` hold their last values after a command; they are only meaningful while a strobe is high.

## Timing
- RX byte valid: one internal pulse, 2 sync cycles + (9.5 × `CLKS_PER_BIT`) after the start edge.
- Write: `write` is high in the cycle after the data byte's valid pulse. `halt` has been high for at least one full byte time (10 × `CLKS_PER_BIT`) before `write`.
- Read: `read` at cycle N, `din` captured at N+1, `tx` start bit begins at N+2. A read occupies `halt` for 2 + 10 × `CLKS_PER_BIT` cycles after `read`.
- `write` and `read` are never high together, never high while `halt` is low, and never high two cycles in a row.

## Configuration
- `DBG_READBACK_EN` defined: the 'R' command, CAPTURE/SEND and the TX serialiser are compiled in.
- `DBG_READBACK_EN` undefined:
  - 0x52 is treated as an unknown byte and sets `err`.
  - `read` is tied to 0 and `tx` is tied to 1; `din` is unused.
  - Only the write path remains.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset: hold `rst`=0 mid-frame, release -> `tx`=1, `halt`=0, `write`=0, `read`=0, `err`=0; no strobe appears afterwards.
- Write: send 0x57, 0x80, 0x05 -> exactly one `write` pulse with `address`=0x80, `dout`=0x05; in `top` the LEDs become R=1, G=0, B=1; `halt` falls the next cycle.
- Read (`DBG_READBACK_EN`): LED register holds 0x05; send 0x52, 0x80 -> one `read` pulse at 0x80; `tx` emits 0x05 (start bit, then 1,0,1,0,0,0,0,0, then stop bit); `halt` falls after the stop bit.
- Errors: send 0x41 -> `err`=1, no strobe. Send 0x57 then 0x80 then nothing -> after 255 bit periods, `halt`=0, `err`=1, no `write`. A following valid 0x57 clears `err`.
- Framing: send 0x57 with stop bit 0 -> byte dropped, `err`=1, parser stays in IDLE.
- Build without `DBG_READBACK_EN`: send 0x52, 0x80 -> `err`=1, `read` never asserts, `tx` stays 1.
